// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared types and constants for the two-way ALU arbiter
//
// Purpose : FSM state encoding, requester indices, counter widths and a
//           saturating-increment helper used by alu_arbiter and rr_arbiter2.
// Ports   : none (package).
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Completed-operation counter width.
  localparam int NB_ALUARBITER_CNT = 16;

  // Latency counter width; wide enough for ALU_LATENCY up to 15.
  localparam int NB_ALUARBITER_LAT = 4;

  function automatic logic [NB_ALUARBITER_CNT-1:0] sat_inc(
    input logic [NB_ALUARBITER_CNT-1:0] value
  );
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin pick
//
// Purpose : chooses which of two requesters is served next. A lone request
//           always wins; on a tie the requester that was not served last wins.
// Ports   : req0_i, req1_i   request lines
//           last_grant_i     index of the requester served most recently
//           grant_o          index of the winner (valid only when valid_o)
//           valid_o          at least one request is present
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic valid_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      grant_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_o = REQ1;
    end else begin
      grant_o = REQ0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters with round-robin grant
//
// Purpose : arbitrates two req/done requesters onto a single ALU. The winner's
//           opcode and operands are registered onto the ALU bus, the result is
//           captured ALU_LATENCY cycles later and returned with a one-cycle
//           done pulse, followed by a one-cycle bubble before re-arbitration.
// Options : ALUARBITER_STATS_EN - when defined, o_cnt0/o_cnt1 count completed
//           operations per requester (saturating); otherwise they read zero.
// Ports   : i_clk, i_reset                   clock, synchronous active-high reset
//           i_req0/1, i_op0/1                request and opcode per requester
//           i_dataA0/1, i_dataB0/1           operands per requester
//           o_done0/1, o_res0/1              completion pulse and held result
//           o_alu_op, o_alu_dataA/B          registered ALU operand bus
//           i_alu_res                        ALU result
//           o_busy                           an operation is in flight
//           o_cnt0/1                         completed-operation counters
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NB_ALUARBITER_DATA = 8,
  parameter int NB_ALUARBITER_OP   = 6,
  parameter int ALU_LATENCY        = 1   // 1..15
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_req0,
  input  logic                          i_req1,
  input  logic [NB_ALUARBITER_OP-1:0]   i_op0,
  input  logic [NB_ALUARBITER_OP-1:0]   i_op1,
  input  logic [NB_ALUARBITER_DATA-1:0] i_dataA0,
  input  logic [NB_ALUARBITER_DATA-1:0] i_dataA1,
  input  logic [NB_ALUARBITER_DATA-1:0] i_dataB0,
  input  logic [NB_ALUARBITER_DATA-1:0] i_dataB1,
  output logic                          o_done0,
  output logic                          o_done1,
  output logic [NB_ALUARBITER_DATA-1:0] o_res0,
  output logic [NB_ALUARBITER_DATA-1:0] o_res1,
  output logic [NB_ALUARBITER_OP-1:0]   o_alu_op,
  output logic [NB_ALUARBITER_DATA-1:0] o_alu_dataA,
  output logic [NB_ALUARBITER_DATA-1:0] o_alu_dataB,
  input  logic [NB_ALUARBITER_DATA-1:0] i_alu_res,
  output logic                          o_busy,
  output logic [NB_ALUARBITER_CNT-1:0]  o_cnt0,
  output logic [NB_ALUARBITER_CNT-1:0]  o_cnt1
);

  // Counter value on the last EXEC cycle, when the ALU result is valid.
  localparam logic [NB_ALUARBITER_LAT-1:0] LAT_LAST = NB_ALUARBITER_LAT'(ALU_LATENCY - 1);

  state_t                          state_q, state_d;
  logic                            last_grant_q, last_grant_d;
  logic                            grant_q, grant_d;
  logic [NB_ALUARBITER_LAT-1:0]    lat_cnt_q, lat_cnt_d;
  logic [NB_ALUARBITER_OP-1:0]     alu_op_q, alu_op_d;
  logic [NB_ALUARBITER_DATA-1:0]   alu_a_q, alu_a_d;
  logic [NB_ALUARBITER_DATA-1:0]   alu_b_q, alu_b_d;
  logic                            done0_q, done0_d;
  logic                            done1_q, done1_d;
  logic [NB_ALUARBITER_DATA-1:0]   res0_q, res0_d;
  logic [NB_ALUARBITER_DATA-1:0]   res1_q, res1_d;

  logic                            arb_grant;
  logic                            arb_valid;

  rr_arbiter2 u_rr_arbiter2 (
    .req0_i       (i_req0),
    .req1_i       (i_req1),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    lat_cnt_d    = lat_cnt_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    // Done pulses are only ever raised for the single DONE cycle.
    done0_d      = 1'b0;
    done1_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          lat_cnt_d    = '0;
          if (arb_grant == REQ1) begin
            alu_op_d = i_op1;
            alu_a_d  = i_dataA1;
            alu_b_d  = i_dataB1;
          end else begin
            alu_op_d = i_op0;
            alu_a_d  = i_dataA0;
            alu_b_d  = i_dataB0;
          end
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LAT_LAST) begin
          if (grant_q == REQ1) begin
            res1_d  = i_alu_res;
            done1_d = 1'b1;
          end else begin
            res0_d  = i_alu_res;
            done0_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end

      // Bubble cycle: lets the requester drop req before re-arbitration.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ1;   // requester 0 wins the first tie
      grant_q      <= REQ0;
      lat_cnt_q    <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      res0_q       <= '0;
      res1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      lat_cnt_q    <= lat_cnt_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
    end
  end

  assign o_done0     = done0_q;
  assign o_done1     = done1_q;
  assign o_res0      = res0_q;
  assign o_res1      = res1_q;
  assign o_alu_op    = alu_op_q;
  assign o_alu_dataA = alu_a_q;
  assign o_alu_dataB = alu_b_q;
  assign o_busy      = (state_q != ST_IDLE);

`ifdef ALUARBITER_STATS_EN
  logic [NB_ALUARBITER_CNT-1:0] cnt0_q;
  logic [NB_ALUARBITER_CNT-1:0] cnt1_q;

  // Counting on the next-state done keeps the counter in step with the pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (done0_d) begin
        cnt0_q <= sat_inc(cnt0_q);
      end
      if (done1_d) begin
        cnt1_q <= sat_inc(cnt1_q);
      end
    end
  end

  assign o_cnt0 = cnt0_q;
  assign o_cnt1 = cnt1_q;
`else
  assign o_cnt0 = '0;
  assign o_cnt1 = '0;
`endif

endmodule
